data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words of backing storage (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of dbusy cycles between request acceptance and the response cycle (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-005 The block SHALL have port dreq, input, 1 bit, the access request from the core.
REQ-006 The block SHALL have port dwrite, input, 1 bit: 1 = store, 0 = load; sampled with dreq.
REQ-007 The block SHALL have port daddr, input, 32 bits, the byte address; sampled with dreq.
REQ-008 The block SHALL have port dsize, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved; sampled with dreq.
REQ-009 The block SHALL have port ddata, inout, 32 bits: store data in from the core; load data out to the core.
REQ-010 The block SHALL have port dbusy, output, 1 bit; high while an accepted request is in its latency phase.
REQ-011 The block SHALL have port dready_n, output, 1 bit; an active-low, one-cycle completion strobe.
REQ-012 The block SHALL have port derr, output, 1 bit; a sticky flag set by any misaligned or reserved-size access.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE with dreq=1, the block SHALL capture daddr, dwrite, dsize and ddata (store data) at the clock edge, and go to WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-015 The block SHALL load a 4-bit down-counter with LATENCY-1 on acceptance; WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-016 dbusy SHALL be 1 exactly in WAIT, giving LATENCY cycles; it SHALL never be 1 when LATENCY=0.
REQ-017 In RESP, dready_n SHALL be 0 for exactly one cycle, after which the FSM returns to IDLE; dready_n SHALL be 1 in all other states.
REQ-018 dreq asserted while in WAIT or RESP SHALL be ignored; a new request can be accepted no earlier than the cycle after RESP.
REQ-019 Back-to-back requests SHALL be handled as follows: dreq held high through RESP is accepted in the following IDLE cycle, giving a minimum period of LATENCY+2 cycles.
REQ-020 The word index SHALL be daddr[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses alias and wrap around.
REQ-021 Byte lane selection SHALL be daddr[1:0], little-endian: lane k = word bits [8k+7:8k].
REQ-022 A store SHALL commit at the RESP-cycle clock edge, using only the lanes selected by size: byte = 1 lane; halfword = lanes {addr[1],0} and {addr[1],1}; word = all 4 lanes. The source is ddata right-justified (byte from [7:0], halfword from [15:0]).
REQ-023 For a load, ddata SHALL be driven only during RESP, with the selected data right-justified and zero-extended (sign extension is the core's job); ddata SHALL be high-Z in all other cycles and for stores.
REQ-024 Reads SHALL observe a store to the same address whose RESP occurred in any earlier cycle (no stale data).
REQ-025 A misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) or dsize=11 SHALL complete with normal timing, SHALL modify no memory, SHALL return 0 on a load, and SHALL set derr.
REQ-026 Memory contents SHALL NOT be reset; contents are undefined until written or preloaded by the bench.

Reset
REQ-027 With rst=0 at a clock edge, the block SHALL enter IDLE, set counter=0, dbusy=0, dready_n=1, derr=0, and release ddata to high-Z.
REQ-028 A reset asserted during WAIT or RESP SHALL abort the access: no store commits at that edge and no dready_n pulse occurs afterwards.
REQ-029 While rst=0, dreq SHALL be ignored.

Verification
REQ-030 LATENCY=2: word store of 0xDEADBEEF to 0x100, then word load from 0x100 -> dbusy high 2 cycles, dready_n low 1 cycle, ddata=0xDEADBEEF in the load's RESP cycle.
REQ-031 After word 0x11223344 at 0x200: byte store 0xAA to 0x202, halfword store 0x5566 to 0x200 -> word load returns 0x11AA5566; byte load from 0x203 returns 0x00000011.
REQ-032 Halfword load from 0x201 -> completes in LATENCY+1 cycles, returns 0, derr=1 and stays 1; memory unchanged.
REQ-033 LATENCY=0: dreq held high across 3 loads -> dbusy never high, dready_n pulses every 2 cycles.
REQ-034 rst driven low during the second WAIT cycle of a store to 0x300 -> no dready_n pulse, a subsequent load of 0x300 returns the prior value, and dbusy=0 and dready_n=1 the cycle after the reset edge.
REQ-035 MEM_WORDS=4096: store to 0x00004000 and load from 0x00000000 -> same data returned (wrap-around alias).

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory responder with a
// programmable access latency, byte/halfword/word lanes and a sticky error
// flag for misaligned or reserved-size accesses.
module data_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  inout  wire  [31:0] ddata,
  output logic        dbusy,
  output logic        dready_n,
  output logic        derr
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter start value; unused when the latency phase is skipped entirely.
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // Misaligned halfword/word or reserved size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte enables for an aligned access of the given size.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Merge right-justified store data into the old word on the enabled lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] rep;
    logic [31:0] res;
    logic [3:0]  be;
    case (size)
      2'b00:   rep = {4{wdata[7:0]}};
      2'b01:   rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    be  = lane_enable(size, lane);
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = rep[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Right-justify and zero-extend the selected lanes of a word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = {24'h000000, sh[7:0]};
      2'b01:   res = {16'h0000, sh[15:0]};
      2'b10:   res = word;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  logic [31:0]   mem [MEM_WORDS];

  logic [1:0]    state_q,    state_d;
  logic [3:0]    cnt_q,      cnt_d;
  logic [AW-1:0] idx_q,      idx_d;
  logic [1:0]    lane_q,     lane_d;
  logic [1:0]    size_q,     size_d;
  logic          write_q,    write_d;
  logic          err_q,      err_d;
  logic [31:0]   wdata_q,    wdata_d;
  logic          dbusy_q,    dbusy_d;
  logic          dready_n_q, dready_n_d;
  logic          derr_q,     derr_d;
  logic          oe_q,       oe_d;
  logic [31:0]   rdata_q,    rdata_d;

  logic          enter_resp_s;
  logic [AW-1:0] rd_idx_s;
  logic [1:0]    rd_lane_s;
  logic [1:0]    rd_size_s;
  logic          rd_write_s;
  logic          rd_err_s;
  logic          commit_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^daddr[31:AW+2];

  // Next-state, access capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    size_d       = size_q;
    write_d      = write_q;
    err_d        = err_q;
    wdata_d      = wdata_q;
    enter_resp_s = 1'b0;
    rd_idx_s     = idx_q;
    rd_lane_s    = lane_q;
    rd_size_s    = size_q;
    rd_write_s   = write_q;
    rd_err_s     = err_q;

    case (state_q)
      S_IDLE: begin
        if (dreq) begin
          idx_d   = daddr[AW+1:2];
          lane_d  = daddr[1:0];
          size_d  = dsize;
          write_d = dwrite;
          err_d   = access_err(dsize, daddr[1:0]);
          wdata_d = ddata;
          if (LATENCY == 0) begin
            // Zero latency: the response cycle follows acceptance directly,
            // so the read is set up from the live request.
            state_d      = S_RESP;
            enter_resp_s = 1'b1;
            rd_idx_s     = daddr[AW+1:2];
            rd_lane_s    = daddr[1:0];
            rd_size_s    = dsize;
            rd_write_s   = dwrite;
            rd_err_s     = access_err(dsize, daddr[1:0]);
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    dbusy_d    = (state_d == S_WAIT);
    dready_n_d = (state_d != S_RESP);
    oe_d       = enter_resp_s & ~rd_write_s;
    if (enter_resp_s) begin
      rdata_d = rd_err_s ? 32'h00000000 : load_extract(mem[rd_idx_s], rd_size_s, rd_lane_s);
      derr_d  = derr_q | rd_err_s;
    end else begin
      rdata_d = rdata_q;
      derr_d  = derr_q;
    end

    commit_s = (state_q == S_RESP) & write_q & ~err_q;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= 32'h00000000;
      dbusy_q    <= 1'b0;
      dready_n_q <= 1'b1;
      derr_q     <= 1'b0;
      oe_q       <= 1'b0;
      rdata_q    <= 32'h00000000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      write_q    <= write_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      dbusy_q    <= dbusy_d;
      dready_n_q <= dready_n_d;
      derr_q     <= derr_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
    end
  end

  // Backing store: not reset; a store commits at the response-cycle edge
  // unless reset is asserted at that same edge.
  always_ff @(posedge clk) begin
    if (rst && commit_s) begin
      mem[idx_q] <= store_merge(mem[idx_q], wdata_q, size_q, lane_q);
    end
  end

  assign ddata    = oe_q ? rdata_q : {32{1'bz}};
  assign dbusy    = dbusy_q;
  assign dready_n = dready_n_q;
  assign derr     = derr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for most
// scenarios, LATENCY=0 instance for zero-latency back-to-back loads.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // LATENCY = 2 instance
  logic        dreq2 = 1'b0, dwrite2 = 1'b0, tb_oe2 = 1'b0;
  logic [31:0] daddr2 = 32'h0, tb_wdata2 = 32'h0;
  logic [1:0]  dsize2 = 2'b10;
  wire  [31:0] ddata2;
  logic        dbusy2, dready_n2, derr2;
  assign ddata2 = tb_oe2 ? tb_wdata2 : {32{1'bz}};

  data_mem_responder #(.MEM_WORDS(4096), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .dreq(dreq2), .dwrite(dwrite2), .daddr(daddr2),
    .dsize(dsize2), .ddata(ddata2), .dbusy(dbusy2), .dready_n(dready_n2), .derr(derr2)
  );

  // LATENCY = 0 instance
  logic        dreq0 = 1'b0, dwrite0 = 1'b0, tb_oe0 = 1'b0;
  logic [31:0] daddr0 = 32'h0, tb_wdata0 = 32'h0;
  logic [1:0]  dsize0 = 2'b10;
  wire  [31:0] ddata0;
  logic        dbusy0, dready_n0, derr0;
  assign ddata0 = tb_oe0 ? tb_wdata0 : {32{1'bz}};

  data_mem_responder #(.MEM_WORDS(4096), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .dreq(dreq0), .dwrite(dwrite0), .daddr(daddr0),
    .dsize(dsize0), .ddata(ddata0), .dbusy(dbusy0), .dready_n(dready_n0), .derr(derr0)
  );

  // One access on the LATENCY=2 instance; reports load data, dbusy cycles
  // and the cycle (counted from acceptance) of the dready_n strobe (-1 = none).
  task automatic acc2(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int busy, output int cyc);
    @(negedge clk);
    dreq2 = 1'b1; dwrite2 = wr; daddr2 = a; dsize2 = sz; tb_wdata2 = wd; tb_oe2 = wr;
    @(posedge clk);
    #1;
    dreq2 = 1'b0; tb_oe2 = 1'b0;
    busy = 0; cyc = -1; rd = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dbusy2) busy++;
      if (!dready_n2) begin
        cyc = i;
        rd  = ddata2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; dreq2 = 1'b1; dreq0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dbusy2 !== 1'b0) begin n_bad++; $display("FAIL rst_dbusy: got %b want 0", dbusy2); end
    n_cmp++; if (dready_n2 !== 1'b1) begin n_bad++; $display("FAIL rst_dready_n: got %b want 1", dready_n2); end
    n_cmp++; if (derr2 !== 1'b0) begin n_bad++; $display("FAIL rst_derr: got %b want 0", derr2); end
    n_cmp++; if (dready_n0 !== 1'b1) begin n_bad++; $display("FAIL rst_dready_n0: got %b want 1", dready_n0); end
    rst = 1'b1; dreq2 = 1'b0; dreq0 = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbusy2 !== 1'b0) begin n_bad++; $display("FAIL rst_req_ignored: dbusy got %b want 0", dbusy2); end
  endtask

  task automatic test_word();
    logic [31:0] rd; int busy; int cyc;
    acc2(1'b1, 32'h100, 2'b10, 32'hDEADBEEF, rd, busy, cyc);
    n_cmp++; if (busy != 2) begin n_bad++; $display("FAIL st_busy: got %0d want 2", busy); end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL st_resp_cycle: got %0d want 3", cyc); end
    acc2(1'b0, 32'h100, 2'b10, 32'h0, rd, busy, cyc);
    n_cmp++; if (busy != 2) begin n_bad++; $display("FAIL ld_busy: got %0d want 2", busy); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word: got %h want deadbeef", rd); end
    @(negedge clk);
    n_cmp++; if (dready_n2 !== 1'b1) begin n_bad++; $display("FAIL ready_one_cycle: got %b want 1", dready_n2); end
    n_cmp++; if (derr2 !== 1'b0) begin n_bad++; $display("FAIL derr_clean: got %b want 0", derr2); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; int busy; int cyc;
    acc2(1'b1, 32'h200, 2'b10, 32'h11223344, rd, busy, cyc);
    acc2(1'b1, 32'h202, 2'b00, 32'hFFFFFFAA, rd, busy, cyc);
    acc2(1'b1, 32'h200, 2'b01, 32'hFFFF5566, rd, busy, cyc);
    acc2(1'b0, 32'h200, 2'b10, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h11AA5566) begin n_bad++; $display("FAIL lanes_word: got %h want 11aa5566", rd); end
    acc2(1'b0, 32'h203, 2'b00, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h00000011) begin n_bad++; $display("FAIL lanes_byte3: got %h want 00000011", rd); end
    acc2(1'b0, 32'h201, 2'b00, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h00000055) begin n_bad++; $display("FAIL lanes_byte1: got %h want 00000055", rd); end
    acc2(1'b0, 32'h202, 2'b01, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h000011AA) begin n_bad++; $display("FAIL lanes_half_hi: got %h want 000011aa", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; int busy; int cyc;
    acc2(1'b0, 32'h201, 2'b01, 32'h0, rd, busy, cyc);
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL mis_resp_cycle: got %0d want 3", cyc); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_ld_data: got %h want 00000000", rd); end
    n_cmp++; if (derr2 !== 1'b1) begin n_bad++; $display("FAIL mis_derr: got %b want 1", derr2); end
    acc2(1'b1, 32'h202, 2'b10, 32'hFFFFFFFF, rd, busy, cyc);
    acc2(1'b1, 32'h200, 2'b11, 32'h00000000, rd, busy, cyc);
    acc2(1'b0, 32'h200, 2'b10, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h11AA5566) begin n_bad++; $display("FAIL mis_mem_unchanged: got %h want 11aa5566", rd); end
    n_cmp++; if (derr2 !== 1'b1) begin n_bad++; $display("FAIL derr_sticky: got %b want 1", derr2); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int busy; int cyc; int pulses;
    acc2(1'b1, 32'h300, 2'b10, 32'h12345678, rd, busy, cyc);
    @(negedge clk);
    dreq2 = 1'b1; dwrite2 = 1'b1; daddr2 = 32'h300; dsize2 = 2'b10;
    tb_wdata2 = 32'h0BADC0DE; tb_oe2 = 1'b1;
    @(posedge clk);
    #1;
    dreq2 = 1'b0; tb_oe2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbusy2 !== 1'b0) begin n_bad++; $display("FAIL abort_dbusy: got %b want 0", dbusy2); end
    n_cmp++; if (dready_n2 !== 1'b1) begin n_bad++; $display("FAIL abort_dready_n: got %b want 1", dready_n2); end
    n_cmp++; if (derr2 !== 1'b0) begin n_bad++; $display("FAIL abort_derr_clear: got %b want 0", derr2); end
    rst = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (!dready_n2) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); end
    acc2(1'b0, 32'h300, 2'b10, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL abort_no_commit: got %h want 12345678", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int busy; int cyc;
    acc2(1'b1, 32'h00004000, 2'b10, 32'hCAFEF00D, rd, busy, cyc);
    acc2(1'b0, 32'h00000000, 2'b10, 32'h0, rd, busy, cyc);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap_alias: got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    int first; int second; int busy; logic [31:0] d2;
    first = -1; second = -1; busy = 0; d2 = 32'h0;
    @(negedge clk);
    dreq2 = 1'b1; dwrite2 = 1'b0; daddr2 = 32'h100; dsize2 = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dbusy2) busy++;
      if (!dready_n2) begin
        if (first < 0) first = i;
        else begin second = i; d2 = ddata2; end
      end
    end
    dreq2 = 1'b0;
    n_cmp++; if (first != 3) begin n_bad++; $display("FAIL b2b_first: got %0d want 3", first); end
    n_cmp++; if (second != 7) begin n_bad++; $display("FAIL b2b_period: got %0d want 7", second); end
    n_cmp++; if (busy != 4) begin n_bad++; $display("FAIL b2b_busy: got %0d want 4", busy); end
    n_cmp++; if (d2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_data: got %h want deadbeef", d2); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency0();
    int busy_seen; int pulses; int pat_err; int data_err;
    @(negedge clk);
    dreq0 = 1'b1; dwrite0 = 1'b1; daddr0 = 32'h10; dsize0 = 2'b10;
    tb_wdata0 = 32'hA5A5A5A5; tb_oe0 = 1'b1;
    @(posedge clk);
    #1;
    dreq0 = 1'b0; tb_oe0 = 1'b0;
    @(negedge clk);
    n_cmp++; if (dready_n0 !== 1'b0) begin n_bad++; $display("FAIL l0_st_ready: got %b want 0", dready_n0); end
    @(negedge clk);
    dreq0 = 1'b1; dwrite0 = 1'b0;
    busy_seen = 0; pulses = 0; pat_err = 0; data_err = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (dbusy0) busy_seen++;
      if (dready_n0 !== ((i % 2) == 0)) pat_err++;
      if (!dready_n0) begin
        pulses++;
        if (ddata0 !== 32'hA5A5A5A5) data_err++;
      end
    end
    dreq0 = 1'b0;
    n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL l0_dbusy: got %0d busy cycles want 0", busy_seen); end
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL l0_pulses: got %0d want 3", pulses); end
    n_cmp++; if (pat_err != 0) begin n_bad++; $display("FAIL l0_period: got %0d bad cycles want 0", pat_err); end
    n_cmp++; if (data_err != 0) begin n_bad++; $display("FAIL l0_data: got %0d bad loads want 0", data_err); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_misaligned();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
